// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: packs bytes into 512-bit blocks, appends 0x80, zero fill and 64-bit bit length.
// Optional block handshake counter output blk_cnt is enabled by defining SHA256_PAD_BLKCNT_EN.
module sha256_msg_padder #(
    parameter int LEN_W = 64
) (
    input  logic         clk,
    input  logic         Reset,
    input  logic         byte_valid,
    input  logic [7:0]   byte_data,
    input  logic         byte_last,
    output logic         byte_ready,
    output logic         block_valid,
    output logic [511:0] block,
    output logic         block_last,
    input  logic         block_ready
`ifdef SHA256_PAD_BLKCNT_EN
    ,
    output logic [15:0]  blk_cnt
`endif
);

    typedef enum logic [1:0] {FILL, PAD, EMIT, EMIT_LEN} state_t;

    state_t             state_q;
    logic [6:0]         idx_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   len_d;
    logic               len_pend_q;
    logic               lead80_q;
    logic [511:0]       block_q;
    logic               block_valid_q;
    logic               block_last_q;
    logic [63:0]        len64;
    logic               block_fire;

    assign len_d       = len_q + LEN_W'(8);
    assign len64       = 64'(len_q);
    assign block_fire  = block_valid_q && block_ready;

    assign byte_ready  = (state_q == FILL);
    assign block_valid = block_valid_q;
    assign block       = block_q;
    assign block_last  = block_last_q;

    // Byte n lives in word n/4, most significant byte first within the word.
    function automatic logic [8:0] byte_lsb(input logic [5:0] n);
        return {n[5:2], 5'b0} + {4'b0, ~n[1:0], 3'b0};
    endfunction

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q       <= FILL;
            idx_q         <= '0;
            len_q         <= '0;
            len_pend_q    <= 1'b0;
            lead80_q      <= 1'b0;
            block_q       <= '0;
            block_valid_q <= 1'b0;
            block_last_q  <= 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    if (byte_valid) begin
                        block_q[byte_lsb(idx_q[5:0]) +: 8] <= byte_data;
                        idx_q <= idx_q + 7'd1;
                        len_q <= len_d;
                        if (byte_last) begin
                            state_q <= PAD;
                        end else if (idx_q == 7'd63) begin
                            state_q       <= EMIT;
                            block_valid_q <= 1'b1;
                            block_last_q  <= 1'b0;
                            idx_q         <= '0;
                        end
                    end
                end
                PAD: begin
                    // idx_q == 64 leaves the full block untouched; 0x80 moves to the length block.
                    for (int n = 0; n < 64; n++) begin
                        if (7'(n) == idx_q) begin
                            block_q[byte_lsb(6'(n)) +: 8] <= 8'h80;
                        end else if (7'(n) > idx_q) begin
                            block_q[byte_lsb(6'(n)) +: 8] <= 8'h00;
                        end
                    end
                    if (idx_q <= 7'd55) begin
                        block_q[479:448] <= len64[63:32];
                        block_q[511:480] <= len64[31:0];
                        block_last_q     <= 1'b1;
                        len_pend_q       <= 1'b0;
                    end else begin
                        block_last_q     <= 1'b0;
                        len_pend_q       <= 1'b1;
                        lead80_q         <= (idx_q == 7'd64);
                    end
                    state_q       <= EMIT;
                    block_valid_q <= 1'b1;
                end
                EMIT: begin
                    if (block_ready) begin
                        block_valid_q <= 1'b0;
                        if (len_pend_q) begin
                            state_q      <= EMIT_LEN;
                            block_q      <= {len64[31:0], len64[63:32], 416'b0,
                                             (lead80_q ? 32'h8000_0000 : 32'h0)};
                            block_last_q <= 1'b1;
                            len_pend_q   <= 1'b0;
                        end else begin
                            state_q <= FILL;
                            idx_q   <= '0;
                            if (block_last_q) begin
                                len_q <= '0;
                            end
                        end
                    end
                end
                EMIT_LEN: begin
                    if (!block_valid_q) begin
                        block_valid_q <= 1'b1;
                    end else if (block_ready) begin
                        state_q       <= FILL;
                        block_valid_q <= 1'b0;
                        idx_q         <= '0;
                        len_q         <= '0;
                        lead80_q      <= 1'b0;
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

`ifdef SHA256_PAD_BLKCNT_EN
    logic [15:0] blk_cnt_q;

    always_ff @(posedge clk) begin
        if (Reset) begin
            blk_cnt_q <= '0;
        end else if (block_fire) begin
            blk_cnt_q <= blk_cnt_q + 16'd1;
        end
    end

    assign blk_cnt = blk_cnt_q;
`else
    logic unused_fire;
    assign unused_fire = block_fire;
`endif

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Bench for sha256_msg_padder: padding model in byte arrays, scoreboard of expected blocks, directed messages.
module tb_sha256_msg_padder;

    logic         clk = 1'b0;
    logic         Reset;
    logic         byte_valid;
    logic [7:0]   byte_data;
    logic         byte_last;
    logic         byte_ready;
    logic         block_valid;
    logic [511:0] block;
    logic         block_last;
    logic         block_ready;
    logic [15:0]  blk_cnt;

    int checks = 0;
    int errors = 0;

    logic [511:0] exp_q[$];
    logic         exp_last_q[$];
    logic [7:0]   msg[256];

    always #5 clk = ~clk;

    sha256_msg_padder #(.LEN_W(64)) dut (
        .clk         (clk),
        .Reset       (Reset),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_last   (byte_last),
        .byte_ready  (byte_ready),
        .block_valid (block_valid),
        .block       (block),
        .block_last  (block_last),
        .block_ready (block_ready)
`ifdef SHA256_PAD_BLKCNT_EN
        ,
        .blk_cnt     (blk_cnt)
`endif
    );

`ifndef SHA256_PAD_BLKCNT_EN
    assign blk_cnt = 16'd0;
`endif

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Padded message = msg ++ 0x80 ++ zeros ++ 64-bit big-endian bit count, cut into 64-byte blocks.
    task automatic model_push(input int n);
        logic [7:0]   pb[256];
        logic [63:0]  bl;
        logic [511:0] v;
        logic [31:0]  w;
        int           total;
        total = ((n + 8) / 64 + 1) * 64;
        bl = 64'(n) << 3;
        for (int i = 0; i < 256; i++) pb[i] = (i < n) ? msg[i] : 8'h00;
        pb[n] = 8'h80;
        for (int k = 0; k < 8; k++) pb[total - 8 + k] = 8'(bl >> (56 - 8 * k));
        for (int b = 0; b < total / 64; b++) begin
            v = '0;
            for (int i = 0; i < 16; i++) begin
                w = {pb[64*b + 4*i], pb[64*b + 4*i + 1], pb[64*b + 4*i + 2], pb[64*b + 4*i + 3]};
                v = {w, v[511:32]};
            end
            exp_q.push_back(v);
            exp_last_q.push_back(b == total / 64 - 1);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        int t = 0;
        byte_valid = 1'b1;
        byte_data  = d;
        byte_last  = l;
        while (!byte_ready && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (!byte_ready) begin
            checks++;
            errors++;
            $display("FAIL byte_accept_timeout: byte_ready=0 after %0d cycles, required 1", t);
        end else begin
            @(negedge clk);
        end
        byte_valid = 1'b0;
        byte_last  = 1'b0;
    endtask

    task automatic send_msg(input int n);
        for (int i = 0; i < n; i++) send_byte(msg[i], i == n - 1);
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d blocks still expected, required 0", exp_q.size());
            exp_q.delete();
            exp_last_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic load_abc();
        msg[0] = 8'h61;
        msg[1] = 8'h62;
        msg[2] = 8'h63;
    endtask

    // Scoreboard: every block handshake must match the next expected block.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!Reset && block_valid && block_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_block: got block_last=%0b data=%0h, required no block", block_last, block);
                end else begin
                    check("block_data", block, exp_q.pop_front());
                    check("block_last", 512'(block_last), 512'(exp_last_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [511:0] snap;
        int t;
        Reset       = 1'b1;
        byte_valid  = 1'b0;
        byte_data   = 8'h00;
        byte_last   = 1'b0;
        block_ready = 1'b1;
        repeat (3) @(negedge clk);
        Reset = 1'b0;
        @(negedge clk);
        check("reset_block_valid", 512'(block_valid), 512'(0));
        check("reset_block_last", 512'(block_last), 512'(0));
        check("reset_byte_ready", 512'(byte_ready), 512'(1));
        check("reset_block", block, 512'(0));
`ifdef SHA256_PAD_BLKCNT_EN
        check("reset_blk_cnt", 512'(blk_cnt), 512'(0));
`endif

        // "abc" with latency to block_valid
        load_abc();
        model_push(3);
        check("model_abc_w0", 512'(exp_q[0][31:0]), 512'(32'h6162_6380));
        check("model_abc_w15", 512'(exp_q[0][511:480]), 512'(32'h0000_0018));
        check("model_abc_w1_14", 512'(exp_q[0][479:32]), 512'(0));
        send_msg(3);
        check("abc_pad_cycle_valid", 512'(block_valid), 512'(0));
        check("abc_pad_cycle_ready", 512'(byte_ready), 512'(0));
        @(negedge clk);
        check("abc_latency_valid", 512'(block_valid), 512'(1));
        check("abc_latency_last", 512'(block_last), 512'(1));
        wait_drain();

        // 55 zero bytes: single block
        for (int i = 0; i < 55; i++) msg[i] = 8'h00;
        model_push(55);
        check("model_55_w13", 512'(exp_q[0][447:416]), 512'(32'h0000_0080));
        check("model_55_w15", 512'(exp_q[0][511:480]), 512'(32'h0000_01B8));
        send_msg(55);
        wait_drain();

        // 56 zero bytes: length spills into a second block
        for (int i = 0; i < 56; i++) msg[i] = 8'h00;
        model_push(56);
        check("model_56_b1_w14", 512'(exp_q[0][479:448]), 512'(32'h8000_0000));
        check("model_56_b1_last", 512'(exp_last_q[0]), 512'(0));
        check("model_56_b2_w15", 512'(exp_q[1][511:480]), 512'(32'h0000_01C0));
        check("model_56_b2_w0_14", 512'(exp_q[1][479:0]), 512'(0));
        send_msg(56);
        wait_drain();

        // 64 0xFF bytes: 0x80 leads the extra block
        for (int i = 0; i < 64; i++) msg[i] = 8'hFF;
        model_push(64);
        check("model_64_b1", exp_q[0], {512{1'b1}});
        check("model_64_b2_w0", 512'(exp_q[1][31:0]), 512'(32'h8000_0000));
        check("model_64_b2_w15", 512'(exp_q[1][511:480]), 512'(32'h0000_0200));
        send_msg(64);
        check("full64_pad_cycle_valid", 512'(block_valid), 512'(0));
        @(negedge clk);
        check("full64_latency_valid", 512'(block_valid), 512'(1));
        wait_drain();

        // 100 bytes: full non-final block one cycle after its 64th byte
        for (int i = 0; i < 100; i++) msg[i] = 8'(i * 7 + 3);
        model_push(100);
        for (int i = 0; i < 100; i++) begin
            send_byte(msg[i], i == 99);
            if (i == 63) begin
                check("full_block_latency_valid", 512'(block_valid), 512'(1));
                check("full_block_latency_last", 512'(block_last), 512'(0));
                check("full_block_byte_ready", 512'(byte_ready), 512'(0));
            end
        end
        wait_drain();

        // "abc" with downstream stalled for 10 cycles
        block_ready = 1'b0;
        load_abc();
        model_push(3);
        send_msg(3);
        t = 0;
        while (!block_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        snap = block;
        for (int i = 0; i < 10; i++) begin
            check("stall_valid", 512'(block_valid), 512'(1));
            check("stall_block", block, snap);
            check("stall_last", 512'(block_last), 512'(1));
            check("stall_byte_ready", 512'(byte_ready), 512'(0));
            @(negedge clk);
        end
        block_ready = 1'b1;
        wait_drain();
        check("stall_after_valid", 512'(block_valid), 512'(0));
        check("stall_after_byte_ready", 512'(byte_ready), 512'(1));

        // Reset in mid-message, with a byte offered during reset
        for (int i = 0; i < 30; i++) send_byte(8'(i + 1), 1'b0);
        Reset      = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'h55;
        repeat (2) @(negedge clk);
        byte_valid = 1'b0;
        Reset      = 1'b0;
        @(negedge clk);
        check("midreset_byte_ready", 512'(byte_ready), 512'(1));
        check("midreset_block_valid", 512'(block_valid), 512'(0));
        check("midreset_block", block, 512'(0));
        load_abc();
        model_push(3);
        send_msg(3);
        wait_drain();
`ifdef SHA256_PAD_BLKCNT_EN
        check("midreset_blk_cnt", 512'(blk_cnt), 512'(1));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
